hp0_axi3_slave_mem: RTL and testbench

- AXI3 slave responder for the 64-bit HP0 port; the memory end of the burst traffic that the PL master (loopback, accelerator) issues toward PS DDR. Used in standalone PL simulation and PL-only builds in place of the PS.
- Serves INCR bursts from a local word-addressed RAM covering a window at ADDR_BASE, with independent read and write channel FSMs.

---
 rtl/hp0_axi3_slave_mem_if.sv | 41 ++++
 rtl/hp0_axi3_slave_mem.sv | 130 +++++++++++++
 tb/tb_hp0_axi3_slave_mem.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/hp0_axi3_slave_mem_if.sv
// hp0_axi3_slave_mem_if: AXI3 HP0 bus bundle (AW/W/B/AR/R channels, 64-bit data)
// Ports: none beyond the bundled signals; slave modport for the memory, master for the initiator.
interface hp0_axi3_slave_mem_if #(
  parameter int ID_WIDTH = 6
);
  logic [31:0]         awaddr;
  logic [3:0]          awlen;
  logic [ID_WIDTH-1:0] awid;
  logic                awvalid;
  logic                awready;
  logic [63:0]         wdata;
  logic [7:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [31:0]         araddr;
  logic [3:0]          arlen;
  logic [ID_WIDTH-1:0] arid;
  logic                arvalid;
  logic                arready;
  logic [63:0]         rdata;
  logic [ID_WIDTH-1:0] rid;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;
  modport slave (
    input  awaddr, awlen, awid, awvalid, wdata, wstrb, wlast, wvalid, bready,
           araddr, arlen, arid, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rdata, rid, rresp, rlast, rvalid
  );
  modport master (
    output awaddr, awlen, awid, awvalid, wdata, wstrb, wlast, wvalid, bready,
           araddr, arlen, arid, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rdata, rid, rresp, rlast, rvalid
  );
endinterface

// File: rtl/hp0_axi3_slave_mem.sv
// hp0_axi3_slave_mem: AXI3 INCR-burst memory responder for the 64-bit HP0 port
// Ports: clk, resetn (async active-low), s_axi_hp0 (slave modport of hp0_axi3_slave_mem_if).
// Optional: define HP0_SLAVE_STALL_EN to inject LFSR-driven ready/valid stalls.
module hp0_axi3_slave_mem #(
  parameter logic [31:0] ADDR_BASE      = 32'h1fd00000,
  parameter int          MEM_ADDR_WIDTH = 10,
  parameter int          ID_WIDTH       = 6
) (
  input logic                  clk,
  input logic                  resetn,
  hp0_axi3_slave_mem_if.slave  s_axi_hp0
);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [63:0] mem [2**MEM_ADDR_WIDTH];
  logic [28:0] w_wa, r_wa, w_wrd, r_wrd;
  logic [3:0] w_len, w_cnt, r_len, r_cnt;
  logic [ID_WIDTH-1:0] w_id, r_id;
  logic [63:0] r_data;
  logic w_err, r_err, w_ok, r_ok, w_end, r_end, aw_hs, w_hs, ar_hs;
  logic stall, fetch_hold;
`ifdef HP0_SLAVE_STALL_EN
  logic [15:0] lfsr;
  logic r_dly;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      lfsr  <= 16'hACE1;
      r_dly <= 1'b0;
    end else begin
      lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      r_dly <= r_state == R_FETCH && fetch_hold;
    end
  assign stall      = lfsr[1:0] == 2'b00;
  assign fetch_hold = lfsr[2] && !r_dly;
`else
  assign stall      = 1'b0;
  assign fetch_hold = 1'b0;
`endif
  // Word-granular addressing: the window is checked per beat on the word number.
  assign w_wrd = w_wa - ADDR_BASE[31:3];
  assign r_wrd = r_wa - ADDR_BASE[31:3];
  assign w_ok  = w_wa >= ADDR_BASE[31:3] && w_wrd[28:MEM_ADDR_WIDTH] == '0;
  assign r_ok  = r_wa >= ADDR_BASE[31:3] && r_wrd[28:MEM_ADDR_WIDTH] == '0;
  assign w_end = w_cnt == w_len;
  assign r_end = r_cnt == r_len;
  assign s_axi_hp0.awready = w_state == W_IDLE && !stall;
  assign s_axi_hp0.wready  = w_state == W_DATA && !stall;
  assign s_axi_hp0.bvalid  = w_state == W_RESP;
  assign s_axi_hp0.bresp   = {s_axi_hp0.bvalid && w_err, 1'b0};
  assign s_axi_hp0.bid     = w_id;
  assign s_axi_hp0.arready = r_state == R_IDLE && !stall;
  assign s_axi_hp0.rvalid  = r_state == R_DATA;
  assign s_axi_hp0.rlast   = s_axi_hp0.rvalid && r_end;
  assign s_axi_hp0.rdata   = r_data;
  assign s_axi_hp0.rresp   = {r_err, 1'b0};
  assign s_axi_hp0.rid     = r_id;
  assign aw_hs = s_axi_hp0.awvalid && s_axi_hp0.awready;
  assign w_hs  = s_axi_hp0.wvalid && s_axi_hp0.wready;
  assign ar_hs = s_axi_hp0.arvalid && s_axi_hp0.arready;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  always_comb begin
    w_next = w_state;
    r_next = r_state;
    case (w_state)
      W_IDLE:  w_next = aw_hs ? W_DATA : W_IDLE;
      W_DATA:  w_next = w_hs && w_end ? W_RESP : W_DATA;
      W_RESP:  w_next = s_axi_hp0.bready ? W_IDLE : W_RESP;
      default: w_next = W_IDLE;
    endcase
    case (r_state)
      R_IDLE:  r_next = ar_hs ? R_FETCH : R_IDLE;
      R_FETCH: r_next = fetch_hold ? R_FETCH : R_DATA;
      R_DATA:  r_next = s_axi_hp0.rready ? (r_end ? R_IDLE : R_FETCH) : R_DATA;
      default: r_next = R_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      w_wa   <= '0;
      w_len  <= '0;
      w_cnt  <= '0;
      w_id   <= '0;
      w_err  <= 1'b0;
      r_wa   <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
      r_id   <= '0;
      r_err  <= 1'b0;
      r_data <= '0;
    end else begin
      if (aw_hs) begin
        w_wa  <= s_axi_hp0.awaddr[31:3];
        w_len <= s_axi_hp0.awlen;
        w_id  <= s_axi_hp0.awid;
        w_cnt <= '0;
        w_err <= 1'b0;
      end else if (w_hs) begin
        w_wa  <= w_wa + 29'd1;
        w_cnt <= w_cnt + 4'd1;
        if (!w_ok || s_axi_hp0.wlast != w_end) w_err <= 1'b1;
      end
      if (ar_hs) begin
        r_wa  <= s_axi_hp0.araddr[31:3];
        r_len <= s_axi_hp0.arlen;
        r_id  <= s_axi_hp0.arid;
        r_cnt <= '0;
      end else if (r_state == R_DATA && s_axi_hp0.rready && !r_end) begin
        r_wa  <= r_wa + 29'd1;
        r_cnt <= r_cnt + 4'd1;
      end
      // Reading mem with <= alongside a same-cycle write yields the pre-write word.
      if (r_state == R_FETCH) begin
        r_data <= r_ok ? mem[r_wrd[MEM_ADDR_WIDTH-1:0]] : '0;
        r_err  <= !r_ok;
      end
    end
  always_ff @(posedge clk)
    if (w_hs && w_ok)
      for (int i = 0; i < 8; i++)
        if (s_axi_hp0.wstrb[i]) mem[w_wrd[MEM_ADDR_WIDTH-1:0]][8*i +: 8] <= s_axi_hp0.wdata[8*i +: 8];
endmodule

// File: tb/tb_hp0_axi3_slave_mem.sv
// tb_hp0_axi3_slave_mem: directed scoreboard bench for the HP0 AXI3 memory responder
module tb_hp0_axi3_slave_mem;
  localparam logic [31:0] BASE = 32'h1fd00000;
  localparam int DEPTH = 1024;
  typedef struct packed {logic [63:0] data; logic [1:0] resp; logic last; logic [5:0] id;} rbeat_t;
  typedef struct packed {logic [1:0] resp; logic [5:0] id;} bexp_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  hp0_axi3_slave_mem_if #(.ID_WIDTH(6)) bus ();
  hp0_axi3_slave_mem #(.ADDR_BASE(BASE), .MEM_ADDR_WIDTH(10), .ID_WIDTH(6)) dut (
    .clk(clk), .resetn(resetn), .s_axi_hp0(bus));
  rbeat_t rq[$];
  bexp_t bq[$];
  logic [63:0] model [DEPTH];
  logic [63:0] wd [16];
  logic [7:0] ws [16];
  int n_vec = 0;
  int n_err = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask
  function automatic bit in_win(input logic [31:0] a);
    return a >= BASE && a < BASE + 32'(8 * DEPTH);
  endfunction
  task automatic aw(input logic [31:0] addr, input logic [3:0] len, input logic [5:0] id);
    bus.awaddr = addr; bus.awlen = len; bus.awid = id; bus.awvalid = 1'b1;
    for (int t = 0; !bus.awready; t++) begin
      if (t == 200) begin chk("aw_timeout", 0, 1); break; end
      @(negedge clk);
    end
    @(negedge clk);
    bus.awvalid = 1'b0;
  endtask
  task automatic ar(input logic [31:0] addr, input logic [3:0] len, input logic [5:0] id);
    bus.araddr = addr; bus.arlen = len; bus.arid = id; bus.arvalid = 1'b1;
    for (int t = 0; !bus.arready; t++) begin
      if (t == 200) begin chk("ar_timeout", 0, 1); break; end
      @(negedge clk);
    end
    @(negedge clk);
    bus.arvalid = 1'b0;
  endtask
  task automatic b_get();
    bexp_t e;
    bus.bready = 1'b1;
    for (int t = 0; !bus.bvalid; t++) begin
      if (t == 200) begin chk("b_timeout", 0, 1); break; end
      @(negedge clk);
    end
    e = bq.pop_front();
    chk("bresp", 64'(bus.bresp), 64'(e.resp));
    chk("bid", 64'(bus.bid), 64'(e.id));
    @(negedge clk);
    bus.bready = 1'b0;
  endtask
  task automatic wr_burst(input logic [31:0] addr, input logic [3:0] len, input logic [5:0] id, input int last_at);
    bit err;
    bexp_t e;
    err = 0;
    aw(addr, len, id);
    for (int i = 0; i <= int'(len); i++) begin
      logic [31:0] a;
      a = addr + 32'(8 * i);
      bus.wdata = wd[i]; bus.wstrb = ws[i]; bus.wlast = (i == last_at); bus.wvalid = 1'b1;
      for (int t = 0; !bus.wready; t++) begin
        if (t == 200) begin chk("w_timeout", 0, 1); break; end
        @(negedge clk);
      end
      if (in_win(a)) begin
        for (int b = 0; b < 8; b++)
          if (ws[i][b]) model[(a - BASE) >> 3][8*b +: 8] = wd[i][8*b +: 8];
      end else err = 1;
      if ((i == last_at) != (i == int'(len))) err = 1;
      @(negedge clk);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    e.resp = err ? 2'b10 : 2'b00; e.id = id;
    bq.push_back(e);
    b_get();
  endtask
  task automatic rd_push(input logic [31:0] addr, input logic [3:0] len, input logic [5:0] id);
    rbeat_t e;
    for (int i = 0; i <= int'(len); i++) begin
      logic [31:0] a;
      a = addr + 32'(8 * i);
      e.data = in_win(a) ? model[(a - BASE) >> 3] : 64'd0;
      e.resp = in_win(a) ? 2'b00 : 2'b10;
      e.last = (i == int'(len));
      e.id = id;
      rq.push_back(e);
    end
  endtask
  task automatic r_get(input int n);
    rbeat_t e;
    for (int i = 0; i < n; i++) begin
      bus.rready = 1'b1;
      for (int t = 0; !bus.rvalid; t++) begin
        if (t == 200) begin chk("r_timeout", 0, 1); break; end
        @(negedge clk);
      end
      e = rq.pop_front();
      chk("rdata", bus.rdata, e.data);
      chk("rresp", 64'(bus.rresp), 64'(e.resp));
      chk("rlast", 64'(bus.rlast), 64'(e.last));
      chk("rid", 64'(bus.rid), 64'(e.id));
      @(negedge clk);
    end
    bus.rready = 1'b0;
  endtask
  task automatic rd_burst(input logic [31:0] addr, input logic [3:0] len, input logic [5:0] id);
    rd_push(addr, len, id);
    ar(addr, len, id);
    r_get(int'(len) + 1);
  endtask
  initial begin
    rbeat_t e;
    bus.awaddr = '0; bus.awlen = '0; bus.awid = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arlen = '0; bus.arid = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_awready", 64'(bus.awready), 1);
    chk("rst_arready", 64'(bus.arready), 1);
    chk("rst_wready", 64'(bus.wready), 0);
    chk("rst_bvalid", 64'(bus.bvalid), 0);
    chk("rst_rvalid", 64'(bus.rvalid), 0);
    chk("rst_rlast", 64'(bus.rlast), 0);
    chk("rst_resp", 64'({bus.bresp, bus.rresp}), 0);
    chk("rst_ids", 64'({bus.bid, bus.rid}), 0);
    chk("rst_rdata", bus.rdata, 0);
    resetn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin wd[i] = 64'(i + 1); ws[i] = 8'hFF; end
    wr_burst(BASE, 4'd3, 6'h05, 3);
    rd_burst(BASE, 4'd3, 6'h2A);
    wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
    wr_burst(BASE + 32'h40, 4'd0, 6'h01, 0);
    wd[0] = 64'hAAAAAAAABBBBBBBB; ws[0] = 8'h0F;
    wr_burst(BASE + 32'h40, 4'd0, 6'h02, 0);
    e.data = 64'h11223344BBBBBBBB; e.resp = 2'b00; e.last = 1'b1; e.id = 6'h11;
    rq.push_back(e);
    ar(BASE + 32'h40, 4'd0, 6'h11);
    r_get(1);
    for (int i = 0; i < 16; i++) begin wd[i] = 64'hC0DE000000000000 | 64'(i); ws[i] = 8'hFF; end
    wr_burst(BASE + 32'(8 * (DEPTH - 2)), 4'd15, 6'h07, 15);
    rd_burst(BASE + 32'(8 * (DEPTH - 2)), 4'd15, 6'h08);
    rd_burst(BASE - 32'd8, 4'd0, 6'h09);
    for (int i = 0; i < 16; i++) wd[i] = 64'h5A5A000000000000 | 64'(i);
    wr_burst(BASE + 32'h80, 4'd3, 6'h09, 1);
    rd_push(BASE, 4'd3, 6'h03);
    ar(BASE, 4'd3, 6'h03);
    r_get(1);
    for (int t = 0; !bus.rvalid && t < 200; t++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("hold_rdata", bus.rdata, rq[0].data);
      chk("hold_rlast", 64'(bus.rlast), 64'(rq[0].last));
      @(negedge clk);
    end
    r_get(3);
    rd_push(BASE, 4'd3, 6'h04);
    ar(BASE, 4'd3, 6'h04);
    r_get(1);
    for (int t = 0; !bus.rvalid && t < 200; t++) @(negedge clk);
    resetn = 1'b0;
    #1 chk("rst_mid_rvalid", 64'(bus.rvalid), 0);
    rq.delete();
    @(negedge clk);
    chk("rst_next_rvalid", 64'(bus.rvalid), 0);
    resetn = 1'b1;
    #1 chk("post_rst_arready", 64'(bus.arready), 1);
    @(negedge clk);
    rd_burst(BASE, 4'd3, 6'h0C);
    for (int i = 0; i < 16; i++) wd[i] = 64'h0123456789AB0000 + 64'(i * 3);
    wr_burst(BASE + 32'(8 * 256), 4'd15, 6'h0D, 15);
    for (int i = 0; i < 16; i++) wd[i] = 64'hFEDC000000000000 ^ 64'(i * 7);
    fork
      wr_burst(BASE + 32'(8 * 512), 4'd15, 6'h0E, 15);
      rd_burst(BASE + 32'(8 * 256), 4'd15, 6'h0F);
    join
    rd_burst(BASE + 32'(8 * 512), 4'd15, 6'h10);
    rd_burst(BASE, 4'd3, 6'h12);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
